// File: rtl/i2s_mic_rx.sv
// ---------------------------------------------------------------------------
// i2s_mic_rx
//
// Receives the I2S data lines of a MEMS microphone array and turns them into
// parallel PCM frames. Each data line carries two microphones: the left one
// while ws=0 and the right one while ws=1. sck, ws and sd are asynchronous to
// clk_in. They are synchronised, and sck is oversampled to find its rising
// edges. One frame (L and R sample for every line) is emitted per ws period
// over a valid/ready handshake.
//
// Ports
//   clk_in     system clock (60 MHz)
//   rst_n      synchronous active-low reset
//   en         receiver enable; low forces IDLE and discards a partial frame
//   sck        I2S bit clock (async, at most clk_in/4)
//   ws         I2S word select (async, changes on the sck falling edge)
//   sd         serial data, one bit per line (async)
//   out_data   frame; slice k = line k/2, L for even k, R for odd k,
//              at [k*SAMPLE_W +: SAMPLE_W], two's complement
//   out_valid  frame available
//   out_ready  downstream accepts the frame
//   locked     high while receiving the LEFT/RIGHT slots
//   sync_err   one-cycle pulse on a framing error
//   ovf        sticky overrun flag (a finished frame found the output busy)
//   ovf_clr    clears ovf; a simultaneous overrun keeps it set
// ---------------------------------------------------------------------------
module i2s_mic_rx #(
  parameter int NUM_LINES = 4,
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              sck,
  input  logic                              ws,
  input  logic [NUM_LINES-1:0]              sd,
  output logic [2*NUM_LINES*SAMPLE_W-1:0]   out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              locked,
  output logic                              sync_err,
  output logic                              ovf,
  input  logic                              ovf_clr
);

  localparam int CNT_W = $clog2(SLOT_W + 3);
  localparam int FRAME_W = 2 * NUM_LINES * SAMPLE_W;

  localparam logic [CNT_W-1:0] CNT_SAMPLE    = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_SAMPLE_M1 = CNT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_W + 2);
  localparam logic [CNT_W-1:0] CNT_LAST_M1   = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    LEFT,
    RIGHT
  } state_t;

  state_t state;

  // Two-flop synchronisers, plus the previous synchronised sck for edge detection.
  logic                 sck_meta, sck_sync, sck_prev;
  logic                 ws_meta, ws_sync;
  logic [NUM_LINES-1:0] sd_meta, sd_sync;

  // ws value taken at the previous sck rise; a difference marks a slot boundary.
  logic                 ws_d;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SAMPLE_W-1:0]  shift_reg [NUM_LINES];
  logic [SAMPLE_W-1:0]  left_hold [NUM_LINES];

  logic                 sck_rise, ws_edge, ws_rise, ws_fall;
  logic                 capture, slot_full, overlong, right_done;
  logic [SAMPLE_W-1:0]  shift_next [NUM_LINES];
  logic [FRAME_W-1:0]   frame_next;

  assign sck_rise  = sck_sync & ~sck_prev;
  assign ws_edge   = sck_rise & (ws_sync != ws_d);
  assign ws_rise   = ws_edge & ws_sync;
  assign ws_fall   = ws_edge & ~ws_sync;
  // The rise that shows the ws edge is the I2S delay bit, so it never captures.
  assign capture   = sck_rise & ~ws_edge & (bit_cnt < CNT_SAMPLE);
  assign slot_full = (bit_cnt >= CNT_SAMPLE);
  // This rise would take bit_cnt to SLOT_W+2: ws has not toggled within a slot.
  assign overlong  = sck_rise & ~ws_edge & (bit_cnt == CNT_LAST_M1);
  // The last sample bit of the right slot is being shifted in now, so the
  // frame can be assembled from shift_next this same cycle.
  assign right_done = en & (state == RIGHT) & capture & (bit_cnt == CNT_SAMPLE_M1);

  // NOTE: every signal written in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      shift_next[i] = {shift_reg[i][SAMPLE_W-2:0], sd_sync[i]};
      frame_next[(2*i)*SAMPLE_W   +: SAMPLE_W] = left_hold[i];
      frame_next[(2*i+1)*SAMPLE_W +: SAMPLE_W] = shift_next[i];
    end
  end

  // NOTE: all state is written with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      ws_meta   <= 1'b0;
      ws_sync   <= 1'b0;
      sd_meta   <= '0;
      sd_sync   <= '0;
      ws_d      <= 1'b0;
      bit_cnt   <= '0;
      state     <= IDLE;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      // NOTE: the sample registers are plain flops, not RAM, so they are
      // cleared here too; reset then leaves no stale audio behind.
      for (int i = 0; i < NUM_LINES; i++) begin
        shift_reg[i] <= '0;
        left_hold[i] <= '0;
      end
    end else begin
      sck_meta <= sck;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
      ws_meta  <= ws;
      ws_sync  <= ws_meta;
      sd_meta  <= sd;
      sd_sync  <= sd_meta;

      // Bit timing runs regardless of state, so ws_d is always valid
      // when the FSM starts hunting.
      if (sck_rise) begin
        ws_d <= ws_sync;
      end
      if (ws_edge) begin
        bit_cnt <= '0;
      end else if (sck_rise && (bit_cnt < CNT_LAST)) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
      if (capture) begin
        for (int i = 0; i < NUM_LINES; i++) begin
          shift_reg[i] <= shift_next[i];
        end
      end

      sync_err <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= HUNT;
          end
          HUNT: begin
            if (ws_fall) begin
              state  <= LEFT;
              locked <= 1'b1;
            end
          end
          LEFT: begin
            if (ws_rise && slot_full) begin
              for (int i = 0; i < NUM_LINES; i++) begin
                left_hold[i] <= shift_reg[i];
              end
              state <= RIGHT;
            end else if (ws_rise || overlong) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end
          end
          RIGHT: begin
            // The frame was already emitted when the last bit arrived;
            // this edge only checks that the right slot was long enough.
            if (ws_fall && slot_full) begin
              state <= LEFT;
            end else if (ws_fall || overlong) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Output register: a new frame loads only if the slot is empty or is
      // being drained this cycle. Otherwise the new frame is dropped.
      if (right_done && (!out_valid || out_ready)) begin
        out_data  <= frame_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (right_done && out_valid && !out_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2s_mic_rx.md
Name: i2s_mic_rx

Overview:
- Deserialises the I2S MEMS microphone array data lines into parallel PCM frames.
- Runs on the 60 MHz system clock.
- Treats the bit clock (clk_6MHz) and word select (clk_WS = bit clock / 64) from the clock manager as asynchronous sampled inputs.
- Emits one frame (left + right sample per data line) per WS period over a valid/ready handshake to the downstream beamforming/FIFO stage.

Parameters:
- NUM_LINES, 4, number of sd data lines; each carries two mics (L when ws=0, R when ws=1).
- SAMPLE_W, 24, captured bits per slot, MSB first.
- SLOT_W, 32, nominal SCK periods per slot; used for the over-length check.

Ports:
- clk_in  input  1  system clock (60 MHz); one clock domain, reset is synchronous and active-low.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  receiver enable; low forces IDLE.
- sck  input  1  I2S bit clock (async, must be <= clk_in/4).
- ws  input  1  I2S word select (async, changes on sck falling edge).
- sd  input  NUM_LINES  serial data lines (async).
- out_data  output  2*NUM_LINES*SAMPLE_W  frame; slice k = line k/2, L for even k, R for odd k, at [k*SAMPLE_W +: SAMPLE_W], two's complement.
- out_valid  output  1  frame available.
- out_ready  input  1  downstream accepts.
- locked  output  1  high in LEFT/RIGHT states.
- sync_err  output  1  one-cycle pulse on framing error.
- ovf  output  1  sticky overrun flag.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (rst_n=0 at clk_in edge): out_data=0, out_valid=0, locked=0, sync_err=0, ovf=0, state=IDLE, all counters/shift registers 0, synchroniser flops 0.
- Synchronisation: sck, ws, sd each pass a 2-flop synchroniser.
- sck_rise = one-cycle pulse on the synchronised 0->1 transition of sck.
- ws and sd are sampled in the cycle sck_rise is high; ws_d holds the ws value from the previous sck_rise.
- A WS edge is a sck_rise where ws != ws_d.
- That rise is the I2S delay bit and is not captured; bit_cnt <= 0.
- Each subsequent sck_rise with bit_cnt < SAMPLE_W shifts sd[i] into shift register i (MSB first) and increments bit_cnt.
- Rises with SAMPLE_W <= bit_cnt < SLOT_W+2 only increment bit_cnt; the bits are ignored.
- States:
  - IDLE: en=1 -> HUNT.
  - HUNT: wait for WS falling edge (1->0) -> LEFT. Rising edges are ignored.
  - LEFT: on WS rising edge, if bit_cnt >= SAMPLE_W, copy shift regs to L holding regs -> RIGHT; else sync_err pulse -> HUNT.
  - RIGHT: on WS falling edge, if bit_cnt >= SAMPLE_W, a frame is complete -> LEFT; else sync_err -> HUNT.
  - RIGHT also completes the frame on the sck_rise where bit_cnt reaches SAMPLE_W; the later WS edge then only performs the length check.
  - LEFT/RIGHT: bit_cnt reaching SLOT_W+2 without a WS edge -> sync_err pulse -> HUNT.
  - en=0 in any state -> IDLE next cycle. A partial frame is discarded; out_valid/out_data already presented stay held until accepted.
- Frame completion: in the cycle after the SAMPLE_W-th right-slot bit is shifted in:
  - If out_valid=0 or out_ready=1 in that cycle: out_data <= {R,L per line}, out_valid <= 1.
  - Else: the new frame is dropped, ovf <= 1, and out_data is unchanged.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_valid falls the cycle after a transfer unless a new frame loads in the same cycle; if it loads, out_valid stays 1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- ovf_clr=1 clears ovf. If an overrun occurs in the same cycle, set wins and ovf stays 1.
- The first frame after entering LEFT from HUNT is output normally; no frame is emitted from a left slot without a following right slot.
- Reset mid-frame: all state returns to the reset values the next clk_in edge regardless of en/sck.

Test Plan:
- Reset/lock: clk_in 60 MHz, sck 6 MHz, WS toggling every 32 sck, en=1.
  - locked rises after the first WS falling edge.
  - All outputs are 0 during rst_n=0.
- Data capture: line0 L=0x123456, R=0xABCDEF; line3 L=0x800000, R=0x7FFFFF; other lines 0.
  - out_data slices 0/1/6/7 match exactly.
  - out_valid rises 1 clk after the 24th R bit's sck_rise.
- Backpressure: out_ready=0 for 2 frames.
  - The first frame is held stable, the second is dropped, ovf=1.
  - ovf_clr pulse -> ovf=0. Simultaneous overrun and ovf_clr -> ovf stays 1.
- Short slot: WS toggles after 10 sck in the L slot.
  - One sync_err pulse, locked=0, no out_valid.
  - Relocks at the next WS falling edge; the following frame is correct.
- Stuck WS: WS held low for 40 sck.
  - sync_err at the 34th post-edge rise, state HUNT.
- Enable/reset mid-frame: en=0 at bit 12 of the R slot.
  - No frame is emitted and locked=0 next cycle.
  - With en=1 again, the first frame is the next complete L+R pair.
  - Repeat with rst_n=0: everything is 0 next cycle.
